// File: rtl/cnn_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_dma_pkg
//  Description : Constants, encodings and FSM state type shared by the CNN
//                feature/weight fetch request generators.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_dma_pkg;

    localparam int BASE_TIN_DIV_TOUT      = 4;
    localparam int BASE_TIN_DIV_TOUT_LOG2 = 2;

    localparam int AXI_LOG2_MAX_BURST     = 4;
    localparam int AXI_MAX_BURST          = 1 << AXI_LOG2_MAX_BURST;
    localparam int AXI_LOG2_BEAT_BYTES    = 3;

    localparam logic [3:0] TIN_F_8B = 4'b0001;
    localparam logic [3:0] TIN_F_4B = 4'b0010;
    localparam logic [3:0] TIN_F_2B = 4'b0100;
    localparam logic [3:0] TIN_F_1B = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dma_state_t;

    // log2 of the one-hot Tin_factor; illegal encodings behave as 8-bit data
    function automatic logic [1:0] tin_shift(input logic [3:0] tin_factor);
        case (tin_factor)
            TIN_F_4B: tin_shift = 2'd1;
            TIN_F_2B: tin_shift = 2'd2;
            TIN_F_1B: tin_shift = 2'd3;
            default:  tin_shift = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_beat_credit.sv
`default_nettype none
// ============================================================================
//  Module      : dma_beat_credit
//  Description : Outstanding-beat credit counter; burst issue takes credit,
//                each returned beat gives one back.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_beat_credit #(
    parameter int CRED_BEATS = 64,
    parameter int TAKE_W     = 5,
    parameter int CNT_W      = $clog2(CRED_BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_take,
    input  logic [TAKE_W-1:0] i_take_n,
    input  logic              i_ret,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_full_nxt
);

    localparam logic [CNT_W-1:0] c_full = CNT_W'(CRED_BEATS);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_take_amt;
    logic [CNT_W-1:0] w_count_nxt;

    always_comb begin
        w_take_amt  = i_take ? CNT_W'(i_take_n) : '0;
        w_count_nxt = r_count - w_take_amt + CNT_W'(i_ret);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= c_full;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count    = r_count;
    assign o_full     = (r_count == c_full);
    assign o_full_nxt = (w_count_nxt == c_full);

endmodule
`default_nettype wire

// File: rtl/dat_rd_req_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dat_rd_req_gen
//  Description : Walks the input feature map (row, Tin chunk, W-burst, Tout
//                group) and issues credit-limited MCIF read-burst requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module dat_rd_req_gen
    import cnn_dma_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int LOG2_BURST      = 4,
    parameter int LOG2_BEAT_BYTES = 3,
    parameter int W_W             = 10,
    parameter int H_W             = 10,
    parameter int CHD_W           = 7,
    parameter int KK_W            = 4,
    parameter int CRED_BEATS      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [W_W-1:0]        Win,
    input  logic [H_W-1:0]        Hin,
    input  logic [ADDR_W-1:0]     line_stride,
    input  logic [ADDR_W-1:0]     surf_stride,
    input  logic [3:0]            Tin_factor,
    input  logic [CHD_W-1:0]      CH_in_div_Tin,
    input  logic [KK_W-1:0]       CH_in_res_Tin_div_Tout_minus1,
    output logic                  rd_req_vld,
    input  logic                  rd_req_rdy,
    output logic [ADDR_W-1:0]     rd_req_addr,
    output logic [LOG2_BURST-1:0] rd_req_len,
    input  logic                  beat_ret,
    output logic                  busy,
    output logic                  req_done
);

    localparam int c_cnt_w = $clog2(CRED_BEATS + 1);
    localparam int c_kk_w  = (KK_W > BASE_TIN_DIV_TOUT_LOG2 + 3) ? KK_W : BASE_TIN_DIV_TOUT_LOG2 + 3;
    localparam logic [ADDR_W-1:0] c_burst_bytes = ADDR_W'(1) << (LOG2_BURST + LOG2_BEAT_BYTES);
    localparam logic [LOG2_BURST-1:0] c_len_full = {LOG2_BURST{1'b1}};

    dma_state_t r_state, w_state_nxt;

    logic [H_W-1:0]        r_hin, r_hin_max;
    logic [CHD_W-1:0]      r_chin, r_chin_max;
    logic [W_W-1:0]        r_k, r_k_max;
    logic [c_kk_w-1:0]     r_kk, r_kk_full_max, r_kk_res;
    logic [LOG2_BURST-1:0] r_len, r_len_last;
    logic [ADDR_W-1:0]     r_line, r_surf, r_grp_stride;
    logic [ADDR_W-1:0]     r_row_base, r_chunk_base, r_kbase, r_addr;
    logic                  r_vld, r_busy, r_done;

    logic [1:0]            w_tin_sh;
    logic [W_W-1:0]        w_start_k_max;
    logic [LOG2_BURST-1:0] w_start_len_last;
    logic [c_kk_w-1:0]     w_start_kk_full;
    logic [ADDR_W-1:0]     w_start_grp;
    logic [c_kk_w-1:0]     w_kk_max;
    logic                  w_kk_last, w_k_last, w_chin_last, w_hin_last, w_all_last;
    logic [LOG2_BURST-1:0] w_len_k0, w_len_knext;
    logic [LOG2_BURST:0]   w_take_n;
    logic [c_cnt_w-1:0]    w_cred_cnt;
    logic                  w_cred_full, w_cred_full_nxt, w_cred_ok;
    logic                  w_hs, w_drain_done;
    logic [ADDR_W-1:0]     w_kbase_nxt, w_chunk_nxt, w_row_nxt;

    // Group count per full chunk is 4<<shift; the c_kk_w-bit subtract wraps
    // 32 to 0 before the -1, which still yields the correct maximum index.
    always_comb begin
        w_tin_sh         = tin_shift(Tin_factor);
        w_start_k_max    = (Win - W_W'(1)) >> LOG2_BURST;
        w_start_len_last = Win[LOG2_BURST-1:0] - LOG2_BURST'(1);
        w_start_kk_full  = (c_kk_w'(BASE_TIN_DIV_TOUT) << w_tin_sh) - c_kk_w'(1);
        w_start_grp      = surf_stride << (3'(BASE_TIN_DIV_TOUT_LOG2) + {1'b0, w_tin_sh});
    end

    always_comb begin
        w_kk_max     = (r_chin == r_chin_max) ? r_kk_res : r_kk_full_max;
        w_kk_last    = (r_kk == w_kk_max);
        w_k_last     = (r_k == r_k_max);
        w_chin_last  = (r_chin == r_chin_max);
        w_hin_last   = (r_hin == r_hin_max);
        w_all_last   = w_kk_last & w_k_last & w_chin_last & w_hin_last;
        w_len_k0     = (r_k_max == '0) ? r_len_last : c_len_full;
        w_len_knext  = ((r_k + W_W'(1)) == r_k_max) ? r_len_last : c_len_full;
        w_take_n     = {1'b0, r_len} + (LOG2_BURST + 1)'(1);
        w_cred_ok    = (w_cred_cnt >= c_cnt_w'(w_take_n));
        w_hs         = r_vld & rd_req_rdy;
        w_drain_done = w_cred_full | w_cred_full_nxt;
        w_kbase_nxt  = r_kbase + c_burst_bytes;
        w_chunk_nxt  = r_chunk_base + r_grp_stride;
        w_row_nxt    = r_row_base + r_line;
    end

    dma_beat_credit #(
        .CRED_BEATS (CRED_BEATS),
        .TAKE_W     (LOG2_BURST + 1),
        .CNT_W      (c_cnt_w)
    ) u_cred (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_take     (w_hs),
        .i_take_n   (w_take_n),
        .i_ret      (beat_ret),
        .o_count    (w_cred_cnt),
        .o_full     (w_cred_full),
        .o_full_nxt (w_cred_full_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_hs && w_all_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hin         <= '0;
            r_chin        <= '0;
            r_k           <= '0;
            r_kk          <= '0;
            r_hin_max     <= '0;
            r_chin_max    <= '0;
            r_k_max       <= '0;
            r_kk_full_max <= '0;
            r_kk_res      <= '0;
            r_len_last    <= '0;
            r_line        <= '0;
            r_surf        <= '0;
            r_grp_stride  <= '0;
            r_row_base    <= '0;
            r_chunk_base  <= '0;
            r_kbase       <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_vld         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy        <= 1'b1;
                        r_hin         <= '0;
                        r_chin        <= '0;
                        r_k           <= '0;
                        r_kk          <= '0;
                        r_hin_max     <= Hin - H_W'(1);
                        r_chin_max    <= CH_in_div_Tin - CHD_W'(1);
                        r_k_max       <= w_start_k_max;
                        r_len_last    <= w_start_len_last;
                        r_kk_full_max <= w_start_kk_full;
                        r_kk_res      <= c_kk_w'(CH_in_res_Tin_div_Tout_minus1);
                        r_line        <= line_stride;
                        r_surf        <= surf_stride;
                        r_grp_stride  <= w_start_grp;
                        r_row_base    <= base_addr;
                        r_chunk_base  <= base_addr;
                        r_kbase       <= base_addr;
                        r_addr        <= base_addr;
                        r_len         <= (w_start_k_max == '0) ? w_start_len_last : c_len_full;
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        r_vld <= 1'b0;
                        if (!w_kk_last) begin
                            r_kk   <= r_kk + c_kk_w'(1);
                            r_addr <= r_addr + r_surf;
                        end else begin
                            r_kk <= '0;
                            if (!w_k_last) begin
                                r_k     <= r_k + W_W'(1);
                                r_kbase <= w_kbase_nxt;
                                r_addr  <= w_kbase_nxt;
                                r_len   <= w_len_knext;
                            end else begin
                                r_k   <= '0;
                                r_len <= w_len_k0;
                                if (!w_chin_last) begin
                                    r_chin       <= r_chin + CHD_W'(1);
                                    r_chunk_base <= w_chunk_nxt;
                                    r_kbase      <= w_chunk_nxt;
                                    r_addr       <= w_chunk_nxt;
                                end else begin
                                    r_chin <= '0;
                                    if (!w_hin_last) begin
                                        r_hin        <= r_hin + H_W'(1);
                                        r_row_base   <= w_row_nxt;
                                        r_chunk_base <= w_row_nxt;
                                        r_kbase      <= w_row_nxt;
                                        r_addr       <= w_row_nxt;
                                    end else begin
                                        r_hin <= '0;
                                    end
                                end
                            end
                        end
                    end else if (!r_vld) begin
                        // credit only grows while a request waits, so this holds until accepted
                        r_vld <= w_cred_ok;
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_req_vld  = r_vld;
    assign rd_req_addr = r_addr;
    assign rd_req_len  = r_len;
    assign busy        = r_busy;
    assign req_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dat_rd_req_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dat_rd_req_gen
//  Description : Randomized self-checking bench for dat_rd_req_gen against a
//                loop-nest request model and a beat-credit model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dat_rd_req_gen;

    logic        clk = 1'b0;
    logic        rst_n, start, rd_req_rdy, beat_ret;
    logic [31:0] base_addr, line_stride, surf_stride;
    logic [9:0]  Win, Hin;
    logic [3:0]  Tin_factor;
    logic [6:0]  CH_in_div_Tin;
    logic [3:0]  CH_in_res_Tin_div_Tout_minus1;
    logic        rd_req_vld, busy, req_done;
    logic [31:0] rd_req_addr;
    logic [3:0]  rd_req_len;

    always #5 clk = ~clk;

    dat_rd_req_gen dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .start                         (start),
        .base_addr                     (base_addr),
        .Win                           (Win),
        .Hin                           (Hin),
        .line_stride                   (line_stride),
        .surf_stride                   (surf_stride),
        .Tin_factor                    (Tin_factor),
        .CH_in_div_Tin                 (CH_in_div_Tin),
        .CH_in_res_Tin_div_Tout_minus1 (CH_in_res_Tin_div_Tout_minus1),
        .rd_req_vld                    (rd_req_vld),
        .rd_req_rdy                    (rd_req_rdy),
        .rd_req_addr                   (rd_req_addr),
        .rd_req_len                    (rd_req_len),
        .beat_ret                      (beat_ret),
        .busy                          (busy),
        .req_done                      (req_done)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [35:0] exp_q[$];
    int          mcred, outstanding, issued;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_cfg(input logic [31:0] b, input int w, input int h, input int chd,
                           input int tf, input int rs);
        base_addr                     = b;
        Win                           = 10'(w);
        Hin                           = 10'(h);
        CH_in_div_Tin                 = 7'(chd);
        Tin_factor                    = 4'(tf);
        CH_in_res_Tin_div_Tout_minus1 = 4'(rs);
        line_stride                   = 32'(w) << 3;
        surf_stride                   = 32'(h) * (32'(w) << 3);
    endtask

    // Expected request list straight from the address/length formulas.
    task automatic build_model();
        int          kmax, grp, kkmax, l;
        logic [31:0] a;
        exp_q.delete();
        kmax = (int'(Win) - 1) / 16;
        grp  = 4 * int'(Tin_factor);
        for (int h = 0; h < int'(Hin); h++)
            for (int c = 0; c < int'(CH_in_div_Tin); c++) begin
                kkmax = (c == int'(CH_in_div_Tin) - 1) ? int'(CH_in_res_Tin_div_Tout_minus1) : grp - 1;
                for (int k = 0; k <= kmax; k++)
                    for (int kk = 0; kk <= kkmax; kk++) begin
                        a = base_addr + 32'(c * grp + kk) * surf_stride + 32'(h) * line_stride + 32'(k * 128);
                        l = (k == kmax) ? ((int'(Win) % 16) + 15) % 16 : 15;
                        exp_q.push_back({a, 4'(l)});
                    end
            end
    endtask

    task automatic run_fetch(input int rdy_pct, input int ret_pct, input int ret_hold,
                             input int stall_exp, input int abort_after, input bit noise);
        logic        prev_hold = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [3:0]  prev_len = '0;
        logic        done_due = 1'b0;
        logic        finished = 1'b0;
        logic [35:0] e;
        build_model();
        mcred = 64; outstanding = 0; issued = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start", busy, 1);
        for (int cyc = 0; cyc < 30000 && !finished; cyc++) begin
            if (done_due) begin
                check("done_pulse", req_done, 1);
                check("busy_end", busy, 0);
                finished = 1'b1;
            end else begin
                check("no_early_done", req_done, 0);
                check("credit_model", dut.u_cred.o_count, 64'(mcred));
                if (prev_hold) begin
                    check("hold_vld", rd_req_vld, 1);
                    check("hold_addr", rd_req_addr, prev_addr);
                    check("hold_len", rd_req_len, prev_len);
                end
                if (rd_req_vld) check("issue_credit", mcred >= rd_req_len + 1, 1);
                if (stall_exp >= 0 && cyc == ret_hold) begin
                    check("stall_reqs", issued, stall_exp);
                    check("stall_vld", rd_req_vld, 0);
                end
                if (abort_after > 0 && issued >= abort_after && rd_req_vld) begin
                    rd_req_rdy = 1'b0; beat_ret = 1'b0; start = 1'b0;
                    return;
                end
                rd_req_rdy = ($urandom_range(99) < rdy_pct);
                beat_ret   = (cyc >= ret_hold) && (outstanding > 0) && ($urandom_range(99) < ret_pct);
                if (beat_ret) begin outstanding--; mcred++; end
                start      = noise && ($urandom_range(99) < 5);
                prev_hold  = rd_req_vld && !rd_req_rdy;
                prev_addr  = rd_req_addr;
                prev_len   = rd_req_len;
                if (rd_req_vld && rd_req_rdy) begin
                    if (exp_q.size() == 0) check("extra_req", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("req_addr", rd_req_addr, e[35:4]);
                        check("req_len", rd_req_len, e[3:0]);
                    end
                    issued++;
                    mcred       -= rd_req_len + 1;
                    outstanding += rd_req_len + 1;
                end
                done_due = (exp_q.size() == 0) && (outstanding == 0) && (issued > 0);
                @(negedge clk);
            end
        end
        start = 1'b0; rd_req_rdy = 1'b0; beat_ret = 1'b0;
        if (!finished) check("timeout", 0, 1);
        check("all_reqs_seen", exp_q.size(), 0);
    endtask

    initial begin
        int w, h, chd, tf, rs, rmax;
        rst_n = 1'b0; start = 1'b0; rd_req_rdy = 1'b0; beat_ret = 1'b0;
        set_cfg(32'h1000, 20, 2, 1, 1, 1);
        repeat (3) @(negedge clk);
        check("rst_vld", rd_req_vld, 0);
        check("rst_addr", rd_req_addr, 0);
        check("rst_len", rd_req_len, 0);
        check("rst_busy", busy, 0);
        check("rst_done", req_done, 0);
        check("rst_credit", dut.u_cred.o_count, 64);
        rst_n = 1'b1;
        @(negedge clk);

        // directed layout, always-ready with prompt returns
        set_cfg(32'h1000, 20, 2, 1, 1, 1);
        run_fetch(100, 100, 0, -1, 0, 1'b0);
        check("s1_req_count", issued, 8);

        // heavy backpressure plus start pulses while busy
        run_fetch(30, 60, 0, -1, 0, 1'b1);
        check("bp_req_count", issued, 8);

        // credit exhaustion: four 16-beat bursts then stall until returns
        set_cfg(32'h2000, 64, 1, 1, 1, 1);
        run_fetch(100, 100, 60, 4, 0, 1'b0);
        check("cred_req_count", issued, 8);

        // 1-bit data: 32 groups in chunk 0, one group in chunk 1
        set_cfg(32'h4000, 16, 1, 2, 8, 0);
        run_fetch(80, 70, 0, -1, 0, 1'b1);
        check("tf8_req_count", issued, 33);

        // reset with a request pending, then a clean rerun
        set_cfg(32'h1000, 20, 2, 1, 1, 1);
        run_fetch(100, 100, 0, -1, 2, 1'b0);
        check("abort_pending", rd_req_vld, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_vld", rd_req_vld, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", req_done, 0);
        check("mid_rst_credit", dut.u_cred.o_count, 64);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", req_done, 0);
        run_fetch(100, 100, 0, -1, 0, 1'b0);
        check("rerun_req_count", issued, 8);

        for (int it = 0; it < 4; it++) begin
            w    = $urandom_range(1, 40);
            h    = $urandom_range(1, 2);
            chd  = $urandom_range(1, 2);
            tf   = 1 << $urandom_range(0, 2);
            rmax = (4 * tf - 1 > 15) ? 15 : 4 * tf - 1;
            rs   = $urandom_range(0, rmax);
            set_cfg((it == 0) ? 32'hFFFF_FF80 : ($urandom & 32'hFFFF_FFF8), w, h, chd, tf, rs);
            run_fetch($urandom_range(30, 100), $urandom_range(30, 100), 0, -1, 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
